// File: rtl/fft_pkg.sv
// Shared constants, serializer state and index helpers for the FFT output path.
// FFT_BITREV_EN selects bit-reversed -> natural reordering of the stream.
package fft_pkg;

  localparam int FFT_N     = 32;
  localparam int FFT_W     = 16;
  localparam int FFT_LOG2N = 5;

  typedef enum logic {
    IDLE,
    STREAM
  } ser_state_e;

  function automatic logic [FFT_LOG2N-1:0] bitrev(
    input logic [FFT_LOG2N-1:0] idx
  );
    logic [FFT_LOG2N-1:0] r;
    for (int i = 0; i < FFT_LOG2N; i++) begin
      r[i] = idx[FFT_LOG2N-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bitrev_idx.sv
// Maps the natural beat index k onto the buffer read index.
// FFT_BITREV_EN: reverse the index bits; otherwise pass k straight through.
module fft_bitrev_idx
  import fft_pkg::*;
(
  input  logic [FFT_LOG2N-1:0] k,
  output logic [FFT_LOG2N-1:0] rd_idx
);

`ifdef FFT_BITREV_EN
  assign rd_idx = bitrev(k);
`else
  assign rd_idx = k;
`endif

endmodule

// File: rtl/fft_out_serializer.sv
// Captures one 32-point complex frame and streams it out one beat per cycle.
// FFT_BITREV_EN: stream buffer samples in bit-reversed read order.
module fft_out_serializer
  import fft_pkg::*;
(
  input  logic                     clk_MAC,
  input  logic                     rst,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [FFT_N*FFT_W-1:0]   in_re,
  input  logic [FFT_N*FFT_W-1:0]   in_im,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [FFT_W-1:0]         out_re,
  output logic [FFT_W-1:0]         out_im,
  output logic [FFT_LOG2N-1:0]     out_index,
  output logic                     out_last,
  output logic                     frame_done
);

  localparam int N     = FFT_N;
  localparam int W     = FFT_W;
  localparam int LOG2N = FFT_LOG2N;
  localparam logic [LOG2N-1:0] K_LAST = LOG2N'(N-1);

  ser_state_e       state;
  logic [LOG2N-1:0] k;
  logic [LOG2N-1:0] rd_idx;
  logic [W-1:0]     buf_re [N];
  logic [W-1:0]     buf_im [N];
  logic             accept;
  logic             last_k;

  assign accept = out_valid & out_ready;
  assign last_k = (k == K_LAST);

  fft_bitrev_idx u_idx (
    .k      (k),
    .rd_idx (rd_idx)
  );

  always_ff @(posedge clk_MAC) begin
    if (rst) begin
      state      <= IDLE;
      k          <= '0;
      out_valid  <= 1'b0;
      load_ready <= 1'b1;
      frame_done <= 1'b0;
      for (int j = 0; j < N; j++) begin
        buf_re[j] <= '0;
        buf_im[j] <= '0;
      end
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (load_valid) begin
            for (int j = 0; j < N; j++) begin
              buf_re[j] <= in_re[j*W +: W];
              buf_im[j] <= in_im[j*W +: W];
            end
            k          <= '0;
            state      <= STREAM;
            out_valid  <= 1'b1;
            load_ready <= 1'b0;
          end
        end
        STREAM: begin
          if (accept) begin
            if (last_k) begin
              k          <= '0;
              state      <= IDLE;
              out_valid  <= 1'b0;
              load_ready <= 1'b1;
              frame_done <= 1'b1;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
      endcase
    end
  end

  // k and the buffer only change on accepted beats, so the data holds under stall
  assign out_index = k;
  assign out_last  = last_k & out_valid;
  assign out_re    = out_valid ? buf_re[rd_idx] : '0;
  assign out_im    = out_valid ? buf_im[rd_idx] : '0;

endmodule
